// File: rtl/ship_control.sv
// Ship sprite sequencer: once per frame tick it erases the ship,
// moves it from the buttons, then redraws it (plain or with muzzle flash).
module ship_control #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter logic [7:0]  X_START      = 8'd78,
  parameter logic [7:0]  Y_START      = 8'd110,
  parameter logic [7:0]  X_MIN        = 8'd0,
  parameter logic [7:0]  X_MAX        = 8'd155,
  parameter logic [7:0]  STEP         = 8'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       fire,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [1:0] op,
  output logic       enable,
  output logic       plot,
  output logic       busy,
  output logic       frame_overrun
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] FLAST = FW'(FRAME_CYCLES - 1);

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    UPDATE,
    DRAW
  } state_t;

  state_t        state;
  logic [FW-1:0] fcnt;
  logic [4:0]    pcnt;
  logic          fire_q;
  logic          tick;
  logic          last_pix;
  logic          fire_clr;
  logic [8:0]    up9;
  logic [8:0]    lo9;
  logic [7:0]    x_next;

  assign tick     = (fcnt == FLAST);
  assign last_pix = (pcnt == 5'd24);
  assign fire_clr = (state == DRAW) && last_pix && (op == OP_FIRE);

  // 9-bit sums keep the clamps free of wrap-around
  assign up9 = {1'b0, x_pos} + {1'b0, STEP};
  assign lo9 = {1'b0, X_MIN} + {1'b0, STEP};

  always_comb begin
    x_next = x_pos;
    unique case (1'b1)
      left && !right: begin
        if ({1'b0, x_pos} < lo9) x_next = X_MIN;
        else                     x_next = x_pos - STEP;
      end
      right && !left: begin
        if (up9 > {1'b0, X_MAX}) x_next = X_MAX;
        else                     x_next = up9[7:0];
      end
      default: x_next = x_pos;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt <= '0;
    end else if (tick) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // a new request in the clearing cycle wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= fire | (fire_q & ~fire_clr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pcnt          <= '0;
      x_pos         <= X_START;
      y_pos         <= Y_START;
      op            <= OP_DRAW;
      enable        <= 1'b0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      if (tick && busy) frame_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state  <= ERASE;
            pcnt   <= '0;
            op     <= OP_ERASE;
            enable <= 1'b1;
            plot   <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ERASE: begin
          if (last_pix) begin
            state  <= UPDATE;
            pcnt   <= '0;
            enable <= 1'b0;
            plot   <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        UPDATE: begin
          state  <= DRAW;
          pcnt   <= '0;
          x_pos  <= x_next;
          op     <= fire_q ? OP_FIRE : OP_DRAW;
          enable <= 1'b1;
          plot   <= 1'b1;
        end
        DRAW: begin
          if (last_pix) begin
            state  <= IDLE;
            pcnt   <= '0;
            enable <= 1'b0;
            plot   <= 1'b0;
            busy   <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_control.sv
// Randomized scoreboard bench for ship_control, plus a
// short-frame instance that must flag overruns and clamp at x=0.
module tb_ship_control;

  localparam int FC = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       fire = 1'b0;
  logic       left2 = 1'b1;
  logic       right2 = 1'b0;
  logic       fire2 = 1'b0;
  logic [7:0] x_pos, y_pos, x2, y2;
  logic [1:0] op, op2;
  logic       enable, plot, busy, ovr;
  logic       en2, plot2, busy2, ovr2;

  ship_control #(.FRAME_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n),
    .left(left), .right(right), .fire(fire),
    .x_pos(x_pos), .y_pos(y_pos), .op(op),
    .enable(enable), .plot(plot), .busy(busy),
    .frame_overrun(ovr)
  );

  ship_control #(
    .FRAME_CYCLES(40), .X_START(8'd1), .STEP(8'd2)
  ) dut2 (
    .clk(clk), .reset_n(rst2_n),
    .left(left2), .right(right2), .fire(fire2),
    .x_pos(x2), .y_pos(y2), .op(op2),
    .enable(en2), .plot(plot2), .busy(busy2),
    .frame_overrun(ovr2)
  );

  always #5 clk = ~clk;

  // cycles since reset release; equals the frame phase of the main DUT
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endfunction

  typedef struct {
    int ex;
    int nx;
    int op;
  } pass_t;

  pass_t q[$];

  // main-DUT monitor state
  int phase = 0, inwin = 0, wlen, wop, wx, wy, wbad, wstart;
  int gap = 0, gx, gbusy, bcnt = 0, stray = 0;
  int e_len, e_op, e_x, e_y, e_bad, e_start;

  task automatic finish_pass();
    pass_t e;
    if (q.size() == 0) begin
      chk("pass expected in queue", 0, 1);
    end else begin
      e = q.pop_front();
      chk("erase length", e_len, 25);
      chk("erase op", e_op, 1);
      chk("erase x", e_x, e.ex);
      chk("erase y", e_y, 110);
      chk("erase window unstable", e_bad, 0);
      chk("erase start phase", e_start, 0);
      chk("update x", gx, e.ex);
      chk("update busy", gbusy, 1);
      chk("draw length", wlen, 25);
      chk("draw op", wop, e.op);
      chk("draw x", wx, e.nx);
      chk("draw y", wy, 110);
      chk("draw window unstable", wbad, 0);
      chk("plot outside window", stray, 0);
    end
    stray = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      phase = 0; inwin = 0; bcnt = 0; stray = 0; gap = 0;
    end else begin
      if (busy) begin
        bcnt++;
      end else if (bcnt != 0) begin
        chk("pass busy cycles", bcnt, 51);
        bcnt = 0;
      end
      if (enable) begin
        if (inwin == 0) begin
          inwin = 1; wlen = 0; wop = op; wx = x_pos; wy = y_pos;
          wbad = 0; wstart = cyc % FC;
          if (phase == 1) chk("update gap cycles", gap, 1);
        end
        wlen++;
        if (op != wop || x_pos != wx || y_pos != wy || !plot || !busy)
          wbad = 1;
      end else begin
        if (plot) stray = 1;
        if (inwin == 1) begin
          inwin = 0;
          if (phase == 0) begin
            e_len = wlen; e_op = wop; e_x = wx; e_y = wy;
            e_bad = wbad; e_start = wstart;
            phase = 1; gap = 0; gx = x_pos; gbusy = busy;
          end else begin
            phase = 0;
            finish_pass();
          end
        end
        if (phase == 1) gap++;
      end
    end
  end

  // overrun instance monitor
  int b2 = 0, first2 = 1, np2 = 0;
  initial forever begin
    @(negedge clk);
    if (rst2_n) begin
      if (busy2) begin
        if (b2 == 0 && first2 == 1) begin
          chk("dut2 overrun before overlap", ovr2, 0);
          first2 = 0;
        end
        b2++;
      end else if (b2 != 0) begin
        chk("dut2 pass busy cycles", b2, 51);
        chk("dut2 overrun sticky", ovr2, 1);
        chk("dut2 x clamp", x2, 0);
        np2++;
        b2 = 0;
      end
    end
  end

  int kf = 0;
  int mx = 78;

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc != c && n < 2000);
    if (cyc != c) chk("stimulus sync", cyc, c);
  endtask

  // one frame: optional fire pulses at phase 50 and 56, buttons set at 55
  task automatic frame(input bit l, input bit r, input bit f50, input bit f56);
    int base;
    pass_t e;
    base = FC * kf;
    wait_cyc(base + 50);
    fire = f50;
    wait_cyc(base + 51);
    fire = 1'b0;
    wait_cyc(base + 55);
    left = l;
    right = r;
    wait_cyc(base + 56);
    fire = f56;
    e.ex = mx;
    e.nx = mx;
    if (r && !l) e.nx = mx + 1;
    if (l && !r) e.nx = mx - 1;
    if (e.nx < 0)   e.nx = 0;
    if (e.nx > 155) e.nx = 155;
    e.op = (f50 || f56) ? 2 : 0;
    mx = e.nx;
    q.push_back(e);
    wait_cyc(base + 57);
    fire = 1'b0;
    kf++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset x_pos", x_pos, 78);
    chk("reset y_pos", y_pos, 110);
    chk("reset op", op, 0);
    chk("reset enable", enable, 0);
    chk("reset plot", plot, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", ovr, 0);
    chk("dut2 reset x", x2, 1);
    chk("dut2 reset overrun", ovr2, 0);
    #1;
    reset_n = 1'b1;
    rst2_n = 1'b1;

    repeat (2) frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) frame(1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12)
      frame(($urandom % 2) == 1, ($urandom % 2) == 1,
            ($urandom % 4) == 0, ($urandom % 4) == 0);
    repeat (85)  frame(1'b1, 1'b0, ($urandom % 8) == 0, 1'b0);
    repeat (160) frame(1'b0, 1'b1, 1'b0, ($urandom % 8) == 0);
    repeat (3)   frame(1'b1, 1'b1, 1'b0, 1'b0);

    // reset in the middle of an erase window
    wait_cyc(FC * kf + 12);
    chk("erase active before reset", enable, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset enable", enable, 0);
    chk("async reset plot", plot, 0);
    chk("async reset busy", busy, 0);
    chk("async reset op", op, 0);
    chk("async reset x_pos", x_pos, 78);
    chk("async reset y_pos", y_pos, 110);
    q.delete();
    left = 1'b0;
    right = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    kf = 0;
    mx = 78;
    repeat (2) frame(1'b0, 1'b0, 1'b0, 1'b0);

    wait_cyc(FC * kf + 60);
    chk("all passes drawn", q.size(), 0);
    chk("main overrun", ovr, 0);
    chk("dut2 passes seen", int'(np2 >= 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
